// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin fifo write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1) % n;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester after ptr_i (wrapping) wins.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [PW-1:0]    idx_o,
  output logic             any_o
);

  int unsigned cand;

  // Scan starts one past the last winner so the last owner has lowest priority.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = 32'(ptr_i);
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = ptr_next(cand, N_REQ);
      if (!any_o && req_i[PW'(cand)]) begin
        any_o              = 1'b1;
        grant_o[PW'(cand)] = 1'b1;
        idx_o              = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between N_REQ valid/ready producers,
// with bursts of up to MAX_BURST words and almost_full throttling.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DWIDTH    = 64,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                    clk_i,
  input  logic                    arstn_i,
  input  logic [N_REQ*DWIDTH-1:0] req_data_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [DWIDTH-1:0]       fifo_data_o,
  output logic                    fifo_wrreq_o,
  input  logic                    fifo_full_i,
  input  logic                    fifo_almost_full_i,
  output logic [N_REQ-1:0]        grant_o,
  output logic                    overflow_o
);

  localparam int unsigned PW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               wrreq_q, wrreq_d;
  logic [DWIDTH-1:0]  data_q, data_d;
  logic               ovf_q, ovf_d;

  logic [N_REQ-1:0]   pick_grant;
  logic [PW-1:0]      pick_idx;
  logic               pick_any;
  logic               xfer;
  logic [DWIDTH-1:0]  words [N_REQ];

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      words[i] = req_data_i[i*DWIDTH +: DWIDTH];
    end
  end

  rr_picker #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_picker (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // In BURST ptr_q holds the owner index, so it doubles as the grant select.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    req_ready_o = '0;
    xfer        = 1'b0;
    wrreq_d     = 1'b0;
    data_d      = data_q;
    ovf_d       = ovf_q | (wrreq_q & fifo_full_i);
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BURST;
          grant_d = pick_grant;
          ptr_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      BURST: begin
        req_ready_o[ptr_q] = !fifo_almost_full_i;
        xfer               = req_valid_i[ptr_q] & !fifo_almost_full_i;
        if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (!req_valid_i[ptr_q] || (xfer && cnt_q == CW'(MAX_BURST - 1))) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (xfer) begin
      wrreq_d = 1'b1;
      data_d  = words[ptr_q];
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      ptr_q   <= PW'(N_REQ - 1);
      cnt_q   <= '0;
      grant_q <= '0;
      wrreq_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      wrreq_q <= wrreq_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign grant_o      = grant_q;
  assign fifo_wrreq_o = wrreq_q;
  assign fifo_data_o  = data_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a behavioural 16-deep fifo (almost_full at 14).
module tb_fifo_wr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned MB = 8;

  logic          clk = 1'b0;
  logic          arstn;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_valid, req_ready, grant;
  logic [DW-1:0] fdata;
  logic          fwr, ffull, faf, ovf;
  logic          af_force, full_force, rd;

  logic [DW-1:0] q[$];
  logic [DW-1:0] popped[$];
  int unsigned   used;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [55:0] word;
    logic        af;
    logic [3:0]  ready;
    logic [3:0]  grant;
    logic        wrreq;
    logic [63:0] data;
  } vec_t;
  vec_t tbl[17];

  logic [3:0]  seq[5];
  int unsigned runlen[5], gaps[5], words[5];
  int unsigned ng, sent, s0, max_used, bad;
  logic [3:0]  prev, g;
  bit          tag_ok, hs;

  always #5 clk = ~clk;

  assign faf   = (used >= 14) | af_force;
  assign ffull = (used >= 16) | full_force;

  fifo_wr_arbiter #(
    .N_REQ     (N),
    .DWIDTH    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk_i              (clk),
    .arstn_i            (arstn),
    .req_data_i         (req_data),
    .req_valid_i        (req_valid),
    .req_ready_o        (req_ready),
    .fifo_data_o        (fdata),
    .fifo_wrreq_o       (fwr),
    .fifo_full_i        (ffull),
    .fifo_almost_full_i (faf),
    .grant_o            (grant),
    .overflow_o         (ovf)
  );

  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      q.delete();
      used <= 0;
    end else begin
      if (fwr) q.push_back(fdata);
      if (rd && q.size() > 0) popped.push_back(q.pop_front());
      used <= q.size();
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_words(input logic [55:0] w);
    for (int unsigned i = 0; i < N; i++) req_data[i*DW +: DW] = {8'(i), w};
  endtask

  task automatic reset_dut();
    @(negedge clk);
    arstn = 1'b0;
    req_valid = '0;
    rd = 1'b0;
    af_force = 1'b0;
    full_force = 1'b0;
    popped.delete();
    @(negedge clk);
    arstn = 1'b1;
  endtask

  task automatic prod_cycle();
    set_words(56'(sent));
    @(negedge clk);
    hs = req_valid[1] & req_ready[1];
    @(posedge clk);
    #1;
    if (hs) sent++;
    if (used > max_used) max_used = used;
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    //        valid    word      af    ready    grant    wr    data
    tbl[0]  = '{4'b0001, 56'h00, 1'b0, 4'b0000, 4'b0001, 1'b0, 64'h0};
    tbl[1]  = '{4'b0001, 56'h0A, 1'b0, 4'b0001, 4'b0001, 1'b1, 64'h0A};
    tbl[2]  = '{4'b0001, 56'h0B, 1'b0, 4'b0001, 4'b0001, 1'b1, 64'h0B};
    tbl[3]  = '{4'b0001, 56'h0C, 1'b0, 4'b0001, 4'b0001, 1'b1, 64'h0C};
    tbl[4]  = '{4'b0000, 56'h00, 1'b0, 4'b0001, 4'b0000, 1'b0, 64'h0C};
    tbl[5]  = '{4'b0000, 56'h00, 1'b0, 4'b0000, 4'b0000, 1'b0, 64'h0C};
    tbl[6]  = '{4'b0110, 56'h10, 1'b0, 4'b0000, 4'b0010, 1'b0, 64'h0C};
    tbl[7]  = '{4'b0110, 56'h11, 1'b1, 4'b0000, 4'b0010, 1'b0, 64'h0C};
    tbl[8]  = '{4'b0110, 56'h12, 1'b0, 4'b0010, 4'b0010, 1'b1, 64'h0100_0000_0000_0012};
    tbl[9]  = '{4'b1100, 56'h13, 1'b0, 4'b0010, 4'b0000, 1'b0, 64'h0100_0000_0000_0012};
    tbl[10] = '{4'b1100, 56'h14, 1'b0, 4'b0000, 4'b0100, 1'b0, 64'h0100_0000_0000_0012};
    tbl[11] = '{4'b1100, 56'h15, 1'b0, 4'b0100, 4'b0100, 1'b1, 64'h0200_0000_0000_0015};
    tbl[12] = '{4'b1000, 56'h16, 1'b0, 4'b0100, 4'b0000, 1'b0, 64'h0200_0000_0000_0015};
    tbl[13] = '{4'b1001, 56'h17, 1'b0, 4'b0000, 4'b1000, 1'b0, 64'h0200_0000_0000_0015};
    tbl[14] = '{4'b1001, 56'h18, 1'b0, 4'b1000, 4'b1000, 1'b1, 64'h0300_0000_0000_0018};
    tbl[15] = '{4'b0001, 56'h19, 1'b0, 4'b1000, 4'b0000, 1'b0, 64'h0300_0000_0000_0018};
    tbl[16] = '{4'b0000, 56'h00, 1'b0, 4'b0000, 4'b0000, 1'b0, 64'h0300_0000_0000_0018};

    arstn = 1'b0; req_valid = '0; req_data = '0;
    af_force = 1'b0; full_force = 1'b0; rd = 1'b0;
    #12;
    check("reset_grant", 64'(grant), 64'h0);
    check("reset_wrreq", 64'(fwr), 64'h0);
    check("reset_data", 64'(fdata), 64'h0);
    check("reset_ovf", 64'(ovf), 64'h0);
    check("reset_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    arstn = 1'b1;
    @(posedge clk);
    #1;

    // Single burst, almost_full stall, valid drops, non-owner ignored, rr order
    for (int i = 0; i < 17; i++) begin
      req_valid = tbl[i].valid;
      set_words(tbl[i].word);
      af_force  = tbl[i].af;
      @(negedge clk);
      check($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(tbl[i].ready));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_grant", i), 64'(grant), 64'(tbl[i].grant));
      check($sformatf("vec%0d_wrreq", i), 64'(fwr), 64'(tbl[i].wrreq));
      check($sformatf("vec%0d_data", i), fdata, tbl[i].data);
    end
    af_force = 1'b0;
    rd = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    rd = 1'b0;
    check("single_fifo_count", 64'(popped.size()), 64'd6);
    if (popped.size() >= 3) begin
      check("single_fifo_w0", popped[0], 64'h0A);
      check("single_fifo_w1", popped[1], 64'h0B);
      check("single_fifo_w2", popped[2], 64'h0C);
    end

    // Fairness: all four valid continuously
    reset_dut();
    req_valid = 4'b1111;
    rd = 1'b1;
    ng = 0; prev = '0; tag_ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      seq[k] = '0; runlen[k] = 0; gaps[k] = 0; words[k] = 0;
    end
    for (int c = 0; c < 45; c++) begin
      set_words(56'(c));
      @(posedge clk);
      #1;
      g = grant;
      if (g != 0 && prev == 0 && ng < 5) begin
        seq[ng] = g;
        ng++;
      end
      if (ng > 0) begin
        if (g != 0) runlen[ng-1]++;
        else gaps[ng-1]++;
        if (fwr) begin
          words[ng-1]++;
          if ((4'b0001 << fdata[57:56]) != seq[ng-1] || fdata[63:58] != 6'd0) tag_ok = 1'b0;
        end
      end
      prev = g;
    end
    for (int k = 0; k < 5; k++)
      check($sformatf("rr_grant%0d", k), 64'(seq[k]), 64'(4'b0001 << (k % 4)));
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr_run%0d", k), 64'(runlen[k]), 64'(MB));
      check($sformatf("rr_words%0d", k), 64'(words[k]), 64'(MB));
      check($sformatf("rr_gap%0d", k), 64'(gaps[k]), 64'd1);
    end
    check("rr_data_owner", 64'(tag_ok), 64'd1);
    req_valid = '0;
    repeat (4) @(posedge clk);

    // Fill: req1 streams into a fifo that is not being read
    reset_dut();
    sent = 0; max_used = 0;
    req_valid = 4'b0010;
    for (int c = 0; c < 40; c++) prod_cycle();
    check("fill_max_used_le16", 64'(max_used <= 16), 64'd1);
    check("fill_reached_af", 64'(max_used >= 14), 64'd1);
    check("fill_ready_low", 64'(req_ready), 64'h0);
    check("fill_ovf", 64'(ovf), 64'h0);
    s0 = sent;
    rd = 1'b1;
    for (int c = 0; c < 8; c++) prod_cycle();
    check("fill_resumed", 64'(sent > s0), 64'd1);
    for (int c = 0; c < 200 && sent < 40; c++) prod_cycle();
    check("fill_sent40", 64'(sent >= 40), 64'd1);
    req_valid = '0;
    for (int c = 0; c < 60 && (used != 0 || q.size() != 0); c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("fill_popped_count", 64'(popped.size()), 64'(sent));
    bad = 0;
    foreach (popped[k]) if (popped[k] !== {8'h01, 56'(k)}) bad++;
    check("fill_order", 64'(bad), 64'd0);
    check("fill_ovf_end", 64'(ovf), 64'h0);

    // Reset mid-burst, then first grant must go to requester 0
    reset_dut();
    req_valid = 4'b0100;
    set_words(56'h77);
    repeat (3) @(posedge clk);
    #1;
    check("mid_wrreq_pre", 64'(fwr), 64'd1);
    #2;
    arstn = 1'b0;
    #1;
    check("mid_grant", 64'(grant), 64'h0);
    check("mid_wrreq", 64'(fwr), 64'h0);
    check("mid_data", 64'(fdata), 64'h0);
    check("mid_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    arstn = 1'b1;
    req_valid = 4'b1111;
    @(posedge clk);
    #1;
    check("mid_first_grant", 64'(grant), 64'h1);

    // Overflow: wrreq while fifo reports full sets a sticky flag
    reset_dut();
    rd = 1'b1;
    req_valid = 4'b0001;
    repeat (3) @(posedge clk);
    #1;
    check("ovf_wrreq_pre", 64'(fwr), 64'd1);
    check("ovf_pre", 64'(ovf), 64'h0);
    full_force = 1'b1;
    @(posedge clk);
    #1;
    check("ovf_set", 64'(ovf), 64'd1);
    full_force = 1'b0;
    req_valid = '0;
    repeat (5) @(posedge clk);
    #1;
    check("ovf_sticky", 64'(ovf), 64'd1);
    reset_dut();
    #1;
    check("ovf_cleared", 64'(ovf), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
